// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    DIV_MODE_INT  = 1'b0,
    DIV_MODE_FRAC = 1'b1
  } div_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_e;

  localparam int unsigned DIV_MIN = 2;

  // Only integer-mode odd periods use the negedge phase to stretch the high time.
  function automatic logic odd_phase_en(input div_mode_e mode, input logic period_lsb);
    return (mode == DIV_MODE_INT) && period_lsb;
  endfunction

endpackage

// File: rtl/clk_div_phase_gen.sv
// Output phase generator: posedge duty flop plus negedge half-cycle extension flop.
module clk_div_phase_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period,
  input  logic             odd_en,
  output logic             clk_div
);

  logic q_p;
  logic q_n;
  logic odd_q;

  // cnt/period/odd_en are the values the counter takes at this edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_p   <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      q_p   <= run && (cnt < (period >> 1));
      odd_q <= run && odd_en;
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      q_n <= 1'b0;
    end else begin
      q_n <= q_p && odd_q;
    end
  end

  assign clk_div = q_p | q_n;

endmodule

// File: rtl/clk_divider_prog.sv
// Runtime-programmable integer / dual-modulus fractional clock divider with
// a valid/ready config port; new configs take effect at a period boundary.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned INT_W   = 8,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned RST_DIV = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_mode,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_err,
  output logic              clk_div,
  output logic              div_tick
);

  localparam int unsigned CNT_W = INT_W + 1;

  div_state_e        state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  p_q, p_n;
  logic [FRAC_W-1:0] acc_q, acc_n;
  logic              odd_n;
  logic              tick_n, ready_n, err_n;

  div_mode_e         act_mode_q, act_mode_n;
  logic [INT_W-1:0]  act_int_q, act_int_n;
  logic [FRAC_W-1:0] act_frac_q, act_frac_n;
  div_mode_e         sh_mode_q, sh_mode_n;
  logic [INT_W-1:0]  sh_int_q, sh_int_n;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_n;

  logic              wrap_c, start_c, apply_c, accept_c;
  div_mode_e         sel_mode_c;
  logic [INT_W-1:0]  sel_int_c;
  logic [FRAC_W-1:0] sel_frac_c;
  logic [FRAC_W-1:0] acc_base_c;
  logic [FRAC_W:0]   acc_sum_c;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= CNT_W'(RST_DIV);
      acc_q      <= '0;
      div_tick   <= 1'b0;
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      act_mode_q <= DIV_MODE_INT;
      act_int_q  <= INT_W'(RST_DIV);
      act_frac_q <= '0;
      sh_mode_q  <= DIV_MODE_INT;
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      p_q        <= p_n;
      acc_q      <= acc_n;
      div_tick   <= tick_n;
      cfg_ready  <= ready_n;
      cfg_err    <= err_n;
      act_mode_q <= act_mode_n;
      act_int_q  <= act_int_n;
      act_frac_q <= act_frac_n;
      sh_mode_q  <= sh_mode_n;
      sh_int_q   <= sh_int_n;
      sh_frac_q  <= sh_frac_n;
    end
  end

  // Next-state: counter, period selection, accumulator, handshake.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    p_n        = p_q;
    acc_n      = acc_q;
    odd_n      = odd_phase_en(act_mode_q, p_q[0]);
    tick_n     = 1'b0;
    ready_n    = cfg_ready;
    err_n      = 1'b0;
    act_mode_n = act_mode_q;
    act_int_n  = act_int_q;
    act_frac_n = act_frac_q;
    sh_mode_n  = sh_mode_q;
    sh_int_n   = sh_int_q;
    sh_frac_n  = sh_frac_q;

    wrap_c   = (state_q == ST_RUN) && (cnt_q == p_q - CNT_W'(1));
    start_c  = en && ((state_q == ST_IDLE) || wrap_c);
    apply_c  = !cfg_ready && (!en || start_c);
    accept_c = cfg_valid && cfg_ready;

    sel_mode_c = apply_c ? sh_mode_q : act_mode_q;
    sel_int_c  = apply_c ? sh_int_q  : act_int_q;
    sel_frac_c = apply_c ? sh_frac_q : act_frac_q;
    acc_base_c = apply_c ? '0 : acc_q;
    acc_sum_c  = {1'b0, acc_base_c} + {1'b0, sel_frac_c};

    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      acc_n   = '0;
    end else if (start_c) begin
      // Period length is latched once here so it cannot change mid-period.
      state_n = ST_RUN;
      cnt_n   = '0;
      tick_n  = 1'b1;
      if (sel_mode_c == DIV_MODE_FRAC) begin
        acc_n = acc_sum_c[FRAC_W-1:0];
        p_n   = {1'b0, sel_int_c} + CNT_W'(acc_sum_c[FRAC_W]);
      end else begin
        acc_n = '0;
        p_n   = {1'b0, sel_int_c};
      end
      odd_n = odd_phase_en(sel_mode_c, p_n[0]);
    end else begin
      cnt_n = cnt_q + CNT_W'(1);
    end

    if (apply_c) begin
      act_mode_n = sh_mode_q;
      act_int_n  = sh_int_q;
      act_frac_n = sh_frac_q;
      ready_n    = 1'b1;
    end

    // Accept and apply are mutually exclusive: one needs ready high, the other low.
    if (accept_c) begin
      if (cfg_int < INT_W'(DIV_MIN)) begin
        err_n = 1'b1;
      end else begin
        sh_mode_n = div_mode_e'(cfg_mode);
        sh_int_n  = cfg_int;
        sh_frac_n = cfg_frac;
        ready_n   = 1'b0;
      end
    end
  end

  clk_div_phase_gen #(
    .CNT_W (CNT_W)
  ) u_phase_gen (
    .clk     (clk),
    .rstn    (rstn),
    .run     (en),
    .cnt     (cnt_n),
    .period  (p_n),
    .odd_en  (odd_n),
    .clk_div (clk_div)
  );

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog.
module tb_clk_divider_prog;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_mode;
  logic [7:0] cfg_int;
  logic [7:0] cfg_frac;
  logic       cfg_err;
  logic       clk_div;
  logic       div_tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clk_divider_prog #(
    .INT_W   (8),
    .FRAC_W  (8),
    .RST_DIV (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .cfg_err   (cfg_err),
    .clk_div   (clk_div),
    .div_tick  (div_tick)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(posedge clk or negedge clk);
    #1;
  endtask

  // Present one config for a single accepting edge.
  task automatic offer(input logic mode, input int n, input int f);
    cfg_valid = 1'b1;
    cfg_mode  = mode;
    cfg_int   = 8'(n);
    cfg_frac  = 8'(f);
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int ok);
    int n;
    n = 0;
    while (!cfg_ready && n < 300) begin
      cyc();
      n++;
    end
    ok = cfg_ready ? 1 : 0;
  endtask

  // Cycles between the next two div_tick pulses; -1 on timeout.
  task automatic tick_gap(output int gap);
    int n;
    gap = -1;
    n = 0;
    do begin cyc(); n++; end while (!div_tick && n < 300);
    if (!div_tick) return;
    n = 0;
    do begin cyc(); n++; end while (!div_tick && n < 300);
    if (div_tick) gap = n;
  endtask

  // Period and high time of clk_div in half clk cycles; -1 on timeout.
  task automatic meas(output int per_h, output int hi_h);
    logic prev;
    int   n, hi, lo;
    per_h = -1;
    hi_h  = -1;
    n     = 0;
    prev  = clk_div;
    half();
    while (!(!prev && clk_div) && n < 400) begin
      prev = clk_div;
      half();
      n++;
    end
    if (prev || !clk_div) return;
    hi = 0;
    lo = 0;
    while (clk_div && hi < 400) begin hi++; half(); end
    while (!clk_div && lo < 400) begin lo++; half(); end
    if (clk_div) begin
      hi_h  = hi;
      per_h = hi + lo;
    end
  endtask

  initial begin
    int g, g1, g2, ok, per, hi, cycles, ticks, bad, c, acc;

    rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_mode = 1'b0; cfg_int = '0; cfg_frac = '0;
    repeat (3) cyc();
    check("rst_clk_div", clk_div, 0);
    check("rst_tick", div_tick, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", cfg_ready, 1);

    // Default divide by 4 after reset release.
    en = 1'b1; rstn = 1'b1;
    tick_gap(g);       check("def_tick_gap", g, 4);
    meas(per, hi);     check("def_period_h", per, 8);
                       check("def_high_h", hi, 4);

    // INT N=3: 1.5 clk high via negedge phase.
    offer(1'b0, 3, 0); check("n3_ready_low", cfg_ready, 0);
    wait_ready(ok);    check("n3_ready_wait", ok, 1);
                       check("n3_apply_tick", div_tick, 1);
    meas(per, hi);     check("n3_period_h", per, 6);
                       check("n3_high_h", hi, 3);

    // INT N=10: 5/5.
    offer(1'b0, 10, 0);
    wait_ready(ok);    check("n10_ready_wait", ok, 1);
    meas(per, hi);     check("n10_period_h", per, 20);
                       check("n10_high_h", hi, 10);

    // FRAC 8 + 128/256: alternating 8/9, 256 periods = 2176 cycles.
    offer(1'b1, 8, 128);
    wait_ready(ok);    check("frac_ready_wait", ok, 1);
    cycles = 0; ticks = 0; g1 = 0; g2 = 0;
    while (ticks < 256 && cycles < 4000) begin
      cyc();
      cycles++;
      if (div_tick) begin
        ticks++;
        if (ticks == 1) g1 = cycles;
        if (ticks == 2) g2 = cycles - g1;
      end
    end
    check("frac_pair_sum", g1 + g2, 17);
    check("frac_pair_diff", (g1 > g2) ? g1 - g2 : g2 - g1, 1);
    check("frac_256_cycles", cycles, 2176);

    // Load during cnt=1 of an N=8 period: old period still 8, then 5.
    offer(1'b0, 8, 0);
    wait_ready(ok);    check("n8_ready_wait", ok, 1);
    cyc();
    offer(1'b0, 5, 0);
    c = 2; bad = 0;
    while (!div_tick && c < 300) begin
      if (cfg_ready) bad++;
      cyc();
      c++;
    end
    check("mid_old_period", c, 8);
    check("mid_ready_early", bad, 0);
    check("mid_ready_at_tick", cfg_ready, 1);
    tick_gap(g);       check("mid_new_period", g, 5);

    // Rejected divisors 1 and 0.
    offer(1'b0, 1, 0); check("rej1_err", cfg_err, 1);
                       check("rej1_ready", cfg_ready, 1);
    cyc();             check("rej1_err_clr", cfg_err, 0);
    offer(1'b0, 0, 0); check("rej0_err", cfg_err, 1);
                       check("rej0_ready", cfg_ready, 1);
    cyc();             check("rej0_err_clr", cfg_err, 0);
    tick_gap(g);       check("rej_period_kept", g, 5);

    // Async reset in the high phase with a config pending.
    offer(1'b0, 10, 0);
    check("rstmid_pending", cfg_ready, 0);
    check("rstmid_high", clk_div, 1);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_clk_div", clk_div, 0);
    check("rstmid_ready", cfg_ready, 1);
    check("rstmid_tick", div_tick, 0);
    cyc();
    rstn = 1'b1;
    tick_gap(g);       check("rstmid_gap1", g, 4);
    meas(per, hi);     check("rstmid_period_h", per, 8);
                       check("rstmid_high_h", hi, 4);
    tick_gap(g);       check("rstmid_gap2", g, 4);

    // Disable: idle low, config applied next cycle, restart with a tick.
    en = 1'b0;
    cyc();             check("dis_clk_div", clk_div, 0);
    acc = 0;
    repeat (8) begin
      cyc();
      acc += int'(div_tick) + int'(clk_div);
    end
    check("dis_quiet", acc, 0);
    offer(1'b0, 6, 0); check("dis_accept", cfg_ready, 0);
    cyc();             check("dis_apply", cfg_ready, 1);
    en = 1'b1;
    cyc();             check("en_first_tick", div_tick, 1);
                       check("en_first_high", clk_div, 1);
    tick_gap(g);       check("en_period", g, 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
